// File: rtl/if_fetch_pkg.sv
// Shared constants and payload types for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch entry: an instruction word and the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus decode-side control and IF/ID outputs.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic            stall_i;
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_inst_o;

  modport master (
    input  stall_i, flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
  );

  modport slave (
    output stall_i, flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch FIFO; clear wins over push/pop, push at full is accepted only with a pop.
module if_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, pipelined imem reads, prefetch buffering and the IF/ID latch.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;
  logic             req_c;
  logic             issue;
  logic             push;
  logic             pop;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_inst;

  assign redirect_pc = bus.flush_pc_i & ~32'h0000_0003;

  // Every request reserves a FIFO slot so a response can never find the FIFO full
  assign req_c = !rst && !bus.flush_i
              && (outstanding < CNT_W'(MAX_OUTSTANDING))
              && ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));
  assign issue = req_c && bus.imem_gnt_i;
  assign push  = bus.imem_rvalid_i && (discard == '0) && !bus.flush_i && (!fifo_full || pop);
  assign pop   = !bus.flush_i && !bus.stall_i && !fifo_empty;

  assign fifo_wdata = '{pc: resp_pc, inst: bus.imem_rdata_i};

  assign bus.imem_req_o  = req_c;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.id_valid_o  = id_valid;
  assign bus.id_pc_o     = id_pc;
  assign bus.id_inst_o   = id_inst;

  if_fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .clear (bus.flush_i),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request/response bookkeeping; a redirect turns every still-pending read into a discard
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(bus.imem_rvalid_i);
      if (bus.flush_i) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding - CNT_W'(bus.imem_rvalid_i);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rvalid_i) begin
          if (discard != '0) discard <= discard - CNT_W'(1);
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  // IF/ID latch: flush > stall > advance
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      id_valid <= 1'b0;
      id_pc    <= ZERO_WORD;
      id_inst  <= NOP_INST;
    end else if (!bus.stall_i) begin
      if (pop) begin
        id_valid <= 1'b1;
        id_pc    <= fifo_head.pc;
        id_inst  <= fifo_head.inst;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= ZERO_WORD;
        id_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a queue-based model of memory, prefetch buffer and IF/ID latch.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  pend_t       pend[$];
  ent_t        buf_m[$];
  logic [31:0] exp_fetch;
  bit          exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          first_gnt   = -1;
  int          first_valid = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // One clock: drive inputs after a falling edge, predict, then check the IF/ID outputs
  task automatic step(input bit st, input bit fl, input logic [31:0] fpc, input bit gnt, input bit rv_en);
    pend_t e;
    ent_t  ne;
    bit    rv;
    bit    ereq;
    rv = rv_en && (pend.size() > 0);
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.flush_pc_i    = fpc;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? mem_data(pend[0].addr) : $urandom;
    #1;
    ereq = !fl && (pend.size() < 2) && ((buf_m.size() + pend.size()) < 4);
    check_eq("imem_req", 32'(bus.imem_req_o), 32'(ereq));
    if (ereq) check_eq("imem_addr", bus.imem_addr_o, exp_fetch);

    if (fl) begin
      exp_valid = 1'b0; exp_pc = 32'h0; exp_inst = 32'h0;
    end else if (!st) begin
      if (buf_m.size() > 0) begin
        ne = buf_m.pop_front();
        exp_valid = 1'b1; exp_pc = ne.pc; exp_inst = ne.inst;
      end else begin
        exp_valid = 1'b0; exp_pc = 32'h0; exp_inst = 32'h0;
      end
    end

    if (rv) begin
      e = pend.pop_front();
      if (!fl && !e.stale) begin
        check_eq("fifo_has_space", 32'(buf_m.size() < 4), 32'd1);
        buf_m.push_back('{e.addr, mem_data(e.addr)});
      end
    end

    if (fl) begin
      buf_m.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = fpc & ~32'h0000_0003;
    end else if (ereq && gnt) begin
      if (first_gnt < 0) first_gnt = cyc;
      pend.push_back('{exp_fetch, 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end

    @(negedge clk);
    cyc++;
    if (bus.id_valid_o && first_valid < 0) first_valid = cyc;
    check_eq("id_valid", 32'(bus.id_valid_o), 32'(exp_valid));
    check_eq("id_pc",    bus.id_pc_o,   exp_pc);
    check_eq("id_inst",  bus.id_inst_o, exp_inst);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.flush_pc_i = 32'h0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_req",   32'(bus.imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(bus.id_valid_o), 32'd0);
    check_eq("rst_pc",    bus.id_pc_o,   32'h0);
    check_eq("rst_inst",  bus.id_inst_o, 32'h0);
    rst = 1'b0;
    exp_fetch = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0; exp_inst = 32'h0;

    // Back-to-back streaming from reset
    stream(8);
    check_eq("first_latency", 32'(first_valid - first_gnt), 32'd3);

    // Stall for five cycles mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    stream(6);

    // Redirect with two reads outstanding
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_1003, 1'b1, 1'b0);
    stream(8);

    // Flush and stall together
    step(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
    stream(6);

    // Grant withheld for ten cycles
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    stream(6);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    stream(8);

    // Random mix of stalls, redirects, grant and response timing
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
           $urandom, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
